// File: rtl/ctrlsoc_uart.sv
// ctrlsoc_uart: FIFO-buffered memory-mapped UART for the ctrlsoc picorv32 bus.
//
// Ports:
//   clk        system clock
//   resetn     synchronous, active-low reset
//   rx         serial input (asynchronous, synchronised internally)
//   tx         serial output, idles high
//   mem_valid  access request for this window, held until mem_ready
//   mem_reg    register select (0 DATA, 1 STATUS, 2 DIV, 3 reserved)
//   mem_wstrb  byte write strobes, 0 = read
//   mem_wdata  write data
//   mem_rdata  read data, valid while mem_ready = 1 (0 otherwise)
//   mem_ready  one-cycle completion pulse, the cycle after acceptance
//
// Handshake: an access is taken when mem_valid && !mem_ready. It completes
// with mem_ready high for exactly one cycle after acceptance, except a DATA
// write into a full TX FIFO, which is held off until the cycle in which the
// TX shifter pops a byte (the push then lands in that same cycle).

module ctrlsoc_uart #(
  parameter int unsigned DEFAULT_DIV = 104,
  parameter int unsigned FIFO_LOG2   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  output logic        tx,
  input  logic        mem_valid,
  input  logic [1:0]  mem_reg,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Bus / register file
  logic        r_ready, r_ovr, r_ferr;
  logic [31:0] r_rdata, w_rd_val, w_status;
  logic [15:0] r_div, w_div_eff, w_div_half;
  logic        w_take, w_is_wr, w_tx_wr_req, w_stall, w_accept;
  logic        w_unused_bits;

  // FIFOs
  logic                 w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic                 w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]           w_rx_dout, w_tx_dout;
  logic [FIFO_LOG2:0]   w_rx_count, w_tx_count;

  // RX machine
  uart_state_t r_rx_state, w_rx_state_nx;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [15:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]  r_rx_bit, w_rx_bit_nx;
  logic [7:0]  r_rx_shift, w_rx_shift_nx;
  logic        w_rx_push_req, w_rx_ferr_set, w_rx_ovr_set;

  // TX machine
  uart_state_t r_tx_state, w_tx_state_nx;
  logic [15:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]  r_tx_bit, w_tx_bit_nx;
  logic [7:0]  r_tx_shift, w_tx_shift_nx;
  logic        r_tx, w_tx_line;

  assign w_unused_bits = ^mem_wdata[31:16];  // no register uses the upper half

  assign w_div_eff  = (r_div < 16'd4) ? 16'd4 : r_div;
  // Half a bit, less the two cycles the synchroniser adds before a falling
  // edge is seen, so the start bit is sampled near its centre.
  assign w_div_half = ((w_div_eff >> 1) > 16'd2) ? (w_div_eff >> 1) - 16'd2 : 16'd0;

  // ---------------------------------------------------------------- bus
  assign w_take      = mem_valid && !r_ready;
  assign w_is_wr     = |mem_wstrb;
  assign w_tx_wr_req = w_take && (mem_reg == 2'd0) && mem_wstrb[0];
  // A full TX FIFO still takes the push in a cycle where the shifter pops.
  assign w_stall     = w_tx_wr_req && w_tx_full && !w_tx_pop;
  assign w_accept    = w_take && !w_stall;
  assign w_tx_push   = w_tx_wr_req && !w_stall;
  assign w_rx_pop    = w_accept && (mem_reg == 2'd0) && !w_is_wr && !w_rx_empty;

  assign w_status = {8'h00, 8'(w_tx_count), 8'(w_rx_count), 3'b000, r_ferr, r_ovr,
                     (w_tx_empty && (r_tx_state == ST_IDLE)), w_tx_full, !w_rx_empty};

  always_comb begin
    w_rd_val = 32'h0;
    case (mem_reg)
      2'd0:    w_rd_val = w_rx_empty ? 32'hFFFF_FFFF : {24'h0, w_rx_dout};
      2'd1:    w_rd_val = w_status;
      2'd2:    w_rd_val = {16'h0, r_div};
      default: w_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_div   <= 16'(DEFAULT_DIV);
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !w_is_wr) ? w_rd_val : 32'h0;
      if (w_accept && (mem_reg == 2'd2)) begin
        if (mem_wstrb[0]) r_div[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) r_div[15:8] <= mem_wdata[15:8];
      end
      if (w_accept && (mem_reg == 2'd1) && mem_wstrb[0]) begin
        if (mem_wdata[3]) r_ovr  <= 1'b0;
        if (mem_wdata[4]) r_ferr <= 1'b0;
      end
      // A new event in the same cycle as a clear keeps the flag set.
      if (w_rx_ovr_set)  r_ovr  <= 1'b1;
      if (w_rx_ferr_set) r_ferr <= 1'b1;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;

  // ---------------------------------------------------------------- RX
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= 16'h0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = (r_rx_cnt != 16'h0) ? r_rx_cnt - 16'd1 : r_rx_cnt;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push_req = 1'b0;
    w_rx_ferr_set = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_cnt_nx = r_rx_cnt;
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_nx = ST_START;
          w_rx_cnt_nx   = w_div_half;
        end
      end
      ST_START: if (r_rx_cnt == 16'h0) begin
        // Line back high at mid-start means a glitch: drop it silently.
        w_rx_state_nx = r_rx_s2 ? ST_IDLE : ST_DATA;
        w_rx_cnt_nx   = w_div_eff - 16'd1;
        w_rx_bit_nx   = 3'd0;
      end
      ST_DATA: if (r_rx_cnt == 16'h0) begin
        w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
        w_rx_cnt_nx   = w_div_eff - 16'd1;
        w_rx_bit_nx   = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_state_nx = ST_STOP;
      end
      ST_STOP: if (r_rx_cnt == 16'h0) begin
        w_rx_state_nx = ST_IDLE;
        w_rx_push_req = r_rx_s2;
        w_rx_ferr_set = !r_rx_s2;
      end
      default: w_rx_state_nx = ST_IDLE;
    endcase
  end

  assign w_rx_ovr_set = w_rx_push_req && w_rx_full && !w_rx_pop;
  assign w_rx_push    = w_rx_push_req && !w_rx_ovr_set;

  // ---------------------------------------------------------------- TX
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= 16'h0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx       <= w_tx_line;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = (r_tx_cnt != 16'h0) ? r_tx_cnt - 16'd1 : r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_pop      = 1'b0;
    w_tx_line     = 1'b1;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_nx = r_tx_cnt;
        if (!w_tx_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_state_nx = ST_START;
          w_tx_cnt_nx   = w_div_eff - 16'd1;
          w_tx_shift_nx = w_tx_dout;
        end
      end
      ST_START: begin
        w_tx_line = 1'b0;
        if (r_tx_cnt == 16'h0) begin
          w_tx_state_nx = ST_DATA;
          w_tx_cnt_nx   = w_div_eff - 16'd1;
          w_tx_bit_nx   = 3'd0;
        end
      end
      ST_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (r_tx_cnt == 16'h0) begin
          w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
          w_tx_cnt_nx   = w_div_eff - 16'd1;
          w_tx_bit_nx   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_nx = ST_STOP;
        end
      end
      ST_STOP: if (r_tx_cnt == 16'h0) begin
        // Chain straight into the next start bit so back-to-back bytes
        // have no idle gap.
        if (!w_tx_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_state_nx = ST_START;
          w_tx_cnt_nx   = w_div_eff - 16'd1;
          w_tx_shift_nx = w_tx_dout;
        end else begin
          w_tx_state_nx = ST_IDLE;
        end
      end
      default: w_tx_state_nx = ST_IDLE;
    endcase
  end

  assign tx = r_tx;

  ctrlsoc_uart_fifo #(.LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_data(r_rx_shift), .o_data(w_rx_dout), .o_count(w_rx_count),
    .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  ctrlsoc_uart_fifo #(.LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_data(mem_wdata[7:0]), .o_data(w_tx_dout), .o_count(w_tx_count),
    .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

endmodule

// ctrlsoc_uart_fifo: circular byte FIFO, 2^LOG2 entries.
// Ports: i_push/i_pop requests, i_data in, o_data = head entry,
//        o_count occupancy, o_full/o_empty status.
// A push into a full FIFO is refused unless a pop happens in the same cycle.
module ctrlsoc_uart_fifo #(
  parameter int unsigned LOG2 = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic [LOG2:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned DEPTH = 1 << LOG2;
  localparam logic [LOG2:0] L_FULL = (LOG2 + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [LOG2:0]   r_count;
  logic            w_do_push, w_do_pop;

  assign o_full    = (r_count == L_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (LOG2)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (LOG2)'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (LOG2 + 1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (LOG2 + 1)'(1);
    end
  end

endmodule

// File: tb/tb_ctrlsoc_uart.sv
// Directed bench for ctrlsoc_uart. Two instances: u_dut (defaults, 16-deep
// FIFOs) and u_dut4 (DIV 10, 4-deep FIFOs) share the bus drive lines; sel
// chooses which one sees mem_valid.
module tb_ctrlsoc_uart;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_drv, rx4_drv, loop_en;
  logic        mem_valid;
  logic [1:0]  mem_reg;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  int          sel;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        rx_a, tx_a, valid_a, ready_a;
  logic        tx_4, valid_4, ready_4;
  logic [31:0] rdata_a, rdata_4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx_a    = loop_en ? tx_a : rx_drv;
  assign valid_a = mem_valid && (sel == 0);
  assign valid_4 = mem_valid && (sel == 1);

  ctrlsoc_uart #(.DEFAULT_DIV(104), .FIFO_LOG2(4)) u_dut (
    .clk(clk), .resetn(resetn), .rx(rx_a), .tx(tx_a),
    .mem_valid(valid_a), .mem_reg(mem_reg), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(rdata_a), .mem_ready(ready_a)
  );

  ctrlsoc_uart #(.DEFAULT_DIV(10), .FIFO_LOG2(2)) u_dut4 (
    .clk(clk), .resetn(resetn), .rx(rx4_drv), .tx(tx_4),
    .mem_valid(valid_4), .mem_reg(mem_reg), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(rdata_4), .mem_ready(ready_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus access; rd is X and ok 0 if mem_ready never arrives in budget.
  task automatic bus(input int d, input logic [1:0] r, input logic [3:0] st,
                     input logic [31:0] wd, input int budget,
                     output logic [31:0] rd, output int acc, output bit ok);
    @(negedge clk);
    sel = d; mem_reg = r; mem_wstrb = st; mem_wdata = wd; mem_valid = 1'b1;
    rd = 'x; acc = -1; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((d == 0) ? ready_a : ready_4) begin
        rd  = (d == 0) ? rdata_a : rdata_4;
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic rd_chk(input int d, input logic [1:0] r, input logic [31:0] exp, input string tag);
    logic [31:0] v; int a; bit ok;
    bus(d, r, 4'h0, 32'h0, 20, v, a, ok);
    chk(tag, v, exp);
  endtask

  task automatic wr(input int d, input logic [1:0] r, input logic [3:0] st, input logic [31:0] wd);
    logic [31:0] v; int a; bit ok;
    bus(d, r, st, wd, 20, v, a, ok);
    chk("wr_ack", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (d == 0) rx_drv = f[i]; else rx4_drv = f[i];
      repeat (div) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          n, w;
    bit          ok;
    logic [7:0]  a5;

    resetn = 1'b0; rx_drv = 1'b1; rx4_drv = 1'b1; loop_en = 1'b0;
    mem_valid = 1'b0; mem_reg = 2'd0; mem_wstrb = 4'h0; mem_wdata = 32'h0; sel = 0;

    // 1. reset state
    wait_neg(3);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_tx4", 32'(tx_4), 32'd1);
    resetn = 1'b1;
    rd_chk(0, 2'd1, 32'h0000_0004, "rst_status");
    rd_chk(0, 2'd2, 32'd104, "rst_div");
    rd_chk(0, 2'd0, 32'hFFFF_FFFF, "rst_data_empty");
    chk("idle_tx", 32'(tx_a), 32'd1);

    // 2. transmit 0xA5 at DIV 104, bit-exact timing
    a5 = 8'hA5;
    bus(0, 2'd0, 4'h1, 32'h0000_00A5, 20, v, n, ok);
    chk("tx_wr_ack", 32'(ok), 32'd1);
    wait_neg(1); chk("tx_n1_high", 32'(tx_a), 32'd1);
    wait_neg(1); chk("tx_n2_start", 32'(tx_a), 32'd0);
    wait_neg(103); chk("tx_start_end", 32'(tx_a), 32'd0);
    for (int k = 0; k < 8; k++) begin
      wait_neg((k == 0) ? 1 : 104);
      chk("tx_a5_bit", 32'(tx_a), 32'(a5[k]));
    end
    wait_neg(104); chk("tx_stop", 32'(tx_a), 32'd1);
    wait_neg(100);
    rd_chk(0, 2'd1, 32'h0000_0000, "tx_busy_at_1040");
    rd_chk(0, 2'd1, 32'h0000_0004, "tx_idle_after_1040");

    // 3. loopback at DIV 10
    loop_en = 1'b1;
    wr(0, 2'd2, 4'b0011, 32'd10);
    rd_chk(0, 2'd2, 32'd10, "div10");
    wr(0, 2'd0, 4'h1, 32'h00);
    wr(0, 2'd0, 4'h1, 32'hFF);
    wr(0, 2'd0, 4'h1, 32'h3C);
    wait_neg(400);
    rd_chk(0, 2'd1, 32'h0000_0305, "loop_status_cnt3");
    rd_chk(0, 2'd0, 32'h0000_0000, "loop_rx0");
    rd_chk(0, 2'd0, 32'h0000_00FF, "loop_rx1");
    rd_chk(0, 2'd0, 32'h0000_003C, "loop_rx2");
    rd_chk(0, 2'd0, 32'hFFFF_FFFF, "loop_rx_empty");
    loop_en = 1'b0;

    // 4. overrun on the 4-deep instance
    send_frame(1, 8'h11, 1'b1, 10);
    send_frame(1, 8'h22, 1'b1, 10);
    send_frame(1, 8'h33, 1'b1, 10);
    send_frame(1, 8'h44, 1'b1, 10);
    send_frame(1, 8'h55, 1'b1, 10);
    wait_neg(20);
    rd_chk(1, 2'd1, 32'h0000_040D, "ovr_status");
    wr(1, 2'd1, 4'h1, 32'h0000_0008);
    rd_chk(1, 2'd1, 32'h0000_0405, "ovr_cleared");
    rd_chk(1, 2'd0, 32'h0000_0011, "ovr_first_kept");

    // 5. framing error, glitch rejection, valid frame at DIV 104
    send_frame(0, 8'h5A, 1'b0, 10);
    rx_drv = 1'b1;
    wait_neg(30);
    rd_chk(0, 2'd1, 32'h0000_0014, "ferr_status");
    wr(0, 2'd1, 4'h1, 32'h0000_0010);
    rd_chk(0, 2'd1, 32'h0000_0004, "ferr_cleared");
    wr(0, 2'd2, 4'b0011, 32'd104);
    @(negedge clk); rx_drv = 1'b0;
    wait_neg(3); rx_drv = 1'b1;
    wait_neg(200);
    rd_chk(0, 2'd1, 32'h0000_0004, "glitch_rejected");
    @(negedge clk);
    send_frame(0, 8'hC3, 1'b1, 104);
    wait_neg(5);
    rd_chk(0, 2'd0, 32'h0000_00C3, "rx_div104");

    // DIV byte strobes and the minimum-of-4 clamp
    wr(0, 2'd2, 4'b0010, 32'h1234_0300);
    rd_chk(0, 2'd2, 32'h0000_0368, "div_byte1_only");
    wr(0, 2'd2, 4'b0011, 32'd2);
    rd_chk(0, 2'd2, 32'd2, "div2_readback");
    bus(0, 2'd0, 4'h1, 32'h0000_0001, 20, v, n, ok);
    wait_neg(2); chk("div2_start", 32'(tx_a), 32'd0);
    wait_neg(3); chk("div2_start_end", 32'(tx_a), 32'd0);
    wait_neg(1); chk("div2_bit0", 32'(tx_a), 32'd1);
    wait_neg(4); chk("div2_bit1", 32'(tx_a), 32'd0);
    wait_neg(40);

    // 6. TX full stall, then reset mid-frame
    wr(0, 2'd2, 4'b0011, 32'd10);
    bus(0, 2'd0, 4'h1, 32'h0, 20, v, w, ok);
    for (int i = 0; i < 16; i++) wr(0, 2'd0, 4'h1, 32'h0);
    rd_chk(0, 2'd1, 32'h0010_0002, "tx_full_status");
    bus(0, 2'd0, 4'h1, 32'h0, 300, v, n, ok);
    chk("stall_completed", 32'(ok), 32'd1);
    chk("stall_release_cycle", 32'(n), 32'(w + 101));
    rd_chk(0, 2'd1, 32'h0010_0002, "after_stall_status");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_a == 1'b0) break;
    end
    chk("tx_low_before_reset", 32'(tx_a), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("midframe_rst_tx", 32'(tx_a), 32'd1);
    chk("midframe_rst_ready", 32'(ready_a), 32'd0);
    resetn = 1'b1;
    rd_chk(0, 2'd1, 32'h0000_0004, "post_rst_status");
    rd_chk(0, 2'd2, 32'd104, "post_rst_div");
    rd_chk(0, 2'd3, 32'h0, "reg3_reads_zero");
    wait_neg(50);
    chk("post_rst_tx_idle", 32'(tx_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
